// File: rtl/negator_pkg.sv
// Shared types and lane-limit helpers for the negator datapath.
package negator_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_NEG    = 2'd1,
        MODE_ABS    = 2'd2,
        MODE_SATNEG = 2'd3
    } mode_t;

    localparam int unsigned MAX_INT_W = 64;

    // Most negative two's-complement value of a w-bit lane, zero-extended.
    function automatic logic [MAX_INT_W-1:0] lane_min(input int unsigned w);
        return MAX_INT_W'(1) << (w - 1);
    endfunction

    // Most positive two's-complement value of a w-bit lane, zero-extended.
    function automatic logic [MAX_INT_W-1:0] lane_max(input int unsigned w);
        return (MAX_INT_W'(1) << (w - 1)) - MAX_INT_W'(1);
    endfunction

endpackage

// File: rtl/negator_lane_op.sv
// Combinational single-lane arithmetic: pass, wrapping negate/abs, saturating negate.
module negator_lane_op
    import negator_pkg::*;
#(
    parameter int unsigned INT_W = 32
) (
    input  mode_t              mode,
    input  logic [INT_W-1:0]   x,
    output logic [INT_W-1:0]   y_c
);

    localparam logic [INT_W-1:0] LANE_MIN = INT_W'(lane_min(INT_W));
    localparam logic [INT_W-1:0] LANE_MAX = INT_W'(lane_max(INT_W));

    logic [INT_W-1:0] neg;

    assign neg = -x;

    always_comb begin
        y_c = x;
        case (mode)
            MODE_PASS:   y_c = x;
            MODE_NEG:    y_c = neg;
            MODE_ABS:    y_c = x[INT_W-1] ? neg : x;
            MODE_SATNEG: y_c = (x == LANE_MIN) ? LANE_MAX : neg;
            default:     y_c = x;
        endcase
    end

endmodule

// File: rtl/negator_datapath_pipe.sv
// Lane-parallel negator feeding a bubble-collapsing valid/ready register pipeline.
module negator_datapath_pipe
    import negator_pkg::*;
#(
    parameter int unsigned MEM_W      = 64,
    parameter int unsigned INT_W      = 32,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              input_valid,
    output logic              input_ready,
    input  logic [MEM_W-1:0]  input_data,
    input  mode_t             input_mode,
    output logic              output_valid,
    input  logic              output_ready,
    output logic [MEM_W-1:0]  output_data,
    output logic [CNT_W-1:0]  beat_count
);

    localparam int unsigned LANES = MEM_W / INT_W;
    localparam int unsigned LAST  = PIPE_DEPTH - 1;

    if (MEM_W % INT_W != 0) begin : g_bad_width
        $error("MEM_W must be a multiple of INT_W");
    end
    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("PIPE_DEPTH must be at least 1");
    end
    if (INT_W > MAX_INT_W || INT_W < 2) begin : g_bad_lane
        $error("INT_W out of supported range");
    end

    logic [MEM_W-1:0]      op_data;
    logic [PIPE_DEPTH-1:0] valid_q;
    logic [MEM_W-1:0]      data_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        negator_lane_op #(.INT_W(INT_W)) u_lane (
            .mode (input_mode),
            .x    (input_data[i*INT_W +: INT_W]),
            .y_c  (op_data[i*INT_W +: INT_W])
        );
    end

    // A stage may load when it is empty or its successor is loading this cycle.
    always_comb begin
        advance       = '0;
        advance[LAST] = !valid_q[LAST] || output_ready;
        for (int k = int'(LAST) - 1; k >= 0; k--) begin
            advance[k] = !valid_q[k] || advance[k+1];
        end
    end

    assign input_ready  = advance[0];
    assign output_valid = valid_q[LAST];
    assign output_data  = data_q[LAST];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            beat_count <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (advance[0]) begin
                valid_q[0] <= input_valid;
                data_q[0]  <= op_data;
            end
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                if (advance[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                end
            end
            if (valid_q[LAST] && output_ready) begin
                beat_count <= beat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_negator_datapath_pipe.sv
// Directed bench for negator_datapath_pipe with a queue-based output scoreboard.
module tb_negator_datapath_pipe;
    import negator_pkg::*;

    localparam int unsigned MEM_W = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 32;
    localparam int          BUDGET = 200;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              input_valid = 1'b0;
    logic              input_ready;
    logic [MEM_W-1:0]  input_data = '0;
    mode_t             input_mode = MODE_PASS;
    logic              output_valid;
    logic              output_ready = 1'b0;
    logic [MEM_W-1:0]  output_data;
    logic [CNT_W-1:0]  beat_count;

    negator_datapath_pipe #(
        .MEM_W(MEM_W), .INT_W(32), .PIPE_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_mode   (input_mode),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .beat_count   (beat_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_count = 0;
    int pop_count = 0;
    int last_pop_cyc = 0;
    int prev_pop_cyc = 0;
    logic [MEM_W-1:0] exp_next = '0;
    logic [MEM_W-1:0] exp_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard push: a beat transfers at the next rising edge.
    always @(negedge clock) begin
        if (reset && input_valid && input_ready) begin
            exp_q.push_back(exp_next);
            acc_count++;
        end
    end

    // Monitor: pop and compare every beat the DUT hands downstream.
    always @(negedge clock) begin
        if (reset && output_valid && output_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%h, expected no beat", output_data);
            end else begin
                logic [MEM_W-1:0] e;
                e = exp_q.pop_front();
                if (output_data !== e) begin
                    n_fail++;
                    $display("FAIL out_data: got 0x%h, expected 0x%h", output_data, e);
                end
            end
            pop_count++;
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
        end
    end

    task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [63:0] e);
        int  n;
        logic ok;
        n = 0;
        input_valid = 1'b1;
        input_data  = d;
        input_mode  = mode_t'(m);
        exp_next    = e;
        forever begin
            @(negedge clock);
            ok = input_ready;
            @(posedge clock);
            #1;
            if (ok) break;
            n++;
            if (n >= BUDGET) begin
                check("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            tick();
            n++;
        end
        if (n >= BUDGET) check("drain_timeout", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] base_cnt;
        int               base_acc;

        // Reset state
        #12;
        check("rst_out_valid", 64'(output_valid), 64'(0));
        check("rst_out_data", output_data, 64'(0));
        check("rst_beat_count", 64'(beat_count), 64'(0));
        reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(input_ready), 64'(1));
        output_ready = 1'b1;
        tick();

        // NEG free flow with latency check
        send(64'h00000005_FFFFFFFF, 2'd1, 64'hFFFFFFFB_00000001);
        check("lat_edge1", 64'(output_valid), 64'(0));
        tick();
        check("lat_edge2", 64'(output_valid), 64'(0));
        tick();
        check("lat_edge3", 64'(output_valid), 64'(0));
        tick();
        check("lat_edge4", 64'(output_valid), 64'(1));
        tick();
        check("count_after_first", 64'(beat_count), 64'(1));

        // Min-int corners, back-to-back
        send(64'h80000000_00000001, 2'd1, 64'h80000000_FFFFFFFF);
        send(64'h80000000_00000001, 2'd3, 64'h7FFFFFFF_FFFFFFFF);
        send(64'h80000000_00000001, 2'd2, 64'h80000000_00000001);
        send(64'h80000000_00000001, 2'd0, 64'h80000000_00000001);
        drain();

        // ABS mixed lanes then NEG on the next cycle
        send(64'hFFFFFFF6_0000000A, 2'd2, 64'h0000000A_0000000A);
        send(64'h00000000_FFFFFFFF, 2'd1, 64'h00000000_00000001);
        drain();
        check("no_bubble_gap", 64'(last_pop_cyc - prev_pop_cyc), 64'(1));

        // Backpressure: 8 beats offered while downstream stalls 10 cycles
        base_cnt = beat_count;
        base_acc = acc_count;
        output_ready = 1'b0;
        fork
            begin
                repeat (10) @(posedge clock);
                #1;
                check("bp_accepted", 64'(acc_count - base_acc), 64'(DEPTH));
                check("bp_in_ready", 64'(input_ready), 64'(0));
                check("bp_out_valid", 64'(output_valid), 64'(1));
                check("bp_out_held", output_data, 64'(1));
                output_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 8; i++) send(64'(i), 2'd0, 64'(i));
            end
        join
        drain();
        check("bp_beat_count", 64'(beat_count - base_cnt), 64'(8));

        // Bubble collapse under a permanent stall
        base_acc = acc_count;
        output_ready = 1'b0;
        send(64'h11, 2'd0, 64'h11);
        repeat (3) tick();
        send(64'h22, 2'd0, 64'h22);
        send(64'h33, 2'd0, 64'h33);
        check("bub_ready_before_4th", 64'(input_ready), 64'(1));
        send(64'h44, 2'd0, 64'h44);
        check("bub_ready_after_4th", 64'(input_ready), 64'(0));
        check("bub_accepted", 64'(acc_count - base_acc), 64'(4));
        output_ready = 1'b1;
        drain();

        // Asynchronous reset with beats in flight
        output_ready = 1'b0;
        send(64'hA1, 2'd0, 64'hA1);
        send(64'hA2, 2'd0, 64'hA2);
        send(64'hA3, 2'd0, 64'hA3);
        tick();
        check("pre_rst_valid", 64'(output_valid), 64'(1));
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(output_valid), 64'(0));
        check("mid_rst_count", 64'(beat_count), 64'(0));
        exp_q.delete();
        repeat (2) tick();
        #3;
        reset = 1'b1;
        output_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(input_ready), 64'(1));
        tick();
        send(64'h00000000_00000001, 2'd1, 64'h00000000_FFFFFFFF);
        check("post_lat_edge1", 64'(output_valid), 64'(0));
        tick();
        check("post_lat_edge2", 64'(output_valid), 64'(0));
        tick();
        check("post_lat_edge3", 64'(output_valid), 64'(0));
        tick();
        check("post_lat_edge4", 64'(output_valid), 64'(1));
        drain();
        check("post_rst_count", 64'(beat_count), 64'(1));
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
